reset_seq: RTL and testbench
============================

Name: reset_seq

Overview:
Parametrised reset sequencer that supersedes the fixed single-MAC reset generator.
- Filters PLL lock, times the RGMII PHY hardware reset pulse and PHY wake-up delay, then releases NUM_DOMAINS MAC/datapath reset outputs one after another at fixed intervals.
- Also handles software-requested MAC-only resets and loss of lock.
- Sits at top level between the PLL and the PHY reset pin, driving the gmii_to_rgmii and future MAC channels.

Parameters:
NUM_DOMAINS, 2, number of staged active-high domain resets (1..8)
LOCK_FILT, 8, consecutive pll_lock-high cycles required before sequencing starts (>=1)
PHY_RST_CYCLES, 1000, cycles rgmii_rstn is held low (>=1)
PHY_WAKE_CYCLES, 500, cycles after rgmii_rstn rises before the first domain release (>=1)
STAGE_CYCLES, 16, cycles between successive domain releases (>=1)
LOCK_TIMEOUT, 65536, watchdog limit in LOCK_WAIT (used only with RESET_SEQ_WDOG_EN)

Ports:
clk  input  1  single system clock (PLL output)
rstn  input  1  synchronous, active-low reset
pll_lock  input  1  PLL lock indicator, already synchronous to clk
sw_rst  input  1  single-cycle soft reset request for the MAC domains only
rgmii_rstn  output  1  PHY hardware reset, active-low
dom_rst  output  NUM_DOMAINS  per-domain reset, active-high; bit 0 is released first
ready  output  1  high when all domains are released
state_dbg  output  3  current FSM state encoding
lock_timeout  output  1  sticky watchdog flag (tied 0 without the macro)

Behaviour:
- Interface: one clock, clk; reset rstn is synchronous and active-low. All outputs are registered.
- Reset (rstn=0 at an edge): state LOCK_WAIT, rgmii_rstn=0, dom_rst=all 1, ready=0, lock_timeout=0, all counters=0.
- Timing convention: edge k is the first edge with rstn=1. A state lasting N cycles exits on its Nth edge.
- LOCK_WAIT:
  - Count consecutive edges with pll_lock=1; pll_lock=0 clears the count.
  - On the LOCK_FILT-th consecutive high sample, go to PHY_RST.
- PHY_RST:
  - rgmii_rstn=0.
  - After PHY_RST_CYCLES edges: rgmii_rstn<=1 and go to PHY_WAKE on that same edge.
- PHY_WAKE: after PHY_WAKE_CYCLES edges, dom_rst[0]<=0 and go to RELEASE, stage index=1.
- RELEASE:
  - Every STAGE_CYCLES edges, clear dom_rst[index] and increment the index.
  - On the edge that clears dom_rst[NUM_DOMAINS-1], set ready<=1 and go to RUN.
  - NUM_DOMAINS=1: go from PHY_WAKE directly to RUN, with ready set on the same edge as dom_rst[0].
- RUN: hold all outputs; exit only on lock loss or sw_rst.
- Lock loss (pll_lock=0 in any state except LOCK_WAIT):
  - Next edge: dom_rst=all 1, rgmii_rstn=0, ready=0, counters cleared, go to LOCK_WAIT.
  - Highest priority.
- sw_rst=1 in RELEASE or RUN (lock present):
  - Next edge: dom_rst=all 1, ready=0, go to PHY_WAKE with a cleared counter.
  - rgmii_rstn unaffected.
  - The full PHY_WAKE delay is reapplied.
- sw_rst is ignored in LOCK_WAIT, PHY_RST and PHY_WAKE.
- Simultaneous lock loss and sw_rst: lock loss wins.
- Counter width: $clog2 of the largest cycle parameter, +1. Counters saturate and never wrap.
- state_dbg encoding: LOCK_WAIT=0, PHY_RST=1, PHY_WAKE=2, RELEASE=3, RUN=4.
- dom_rst bits never deassert out of order. Once ready=1, all dom_rst bits are 0.

Optional Feature:
RESET_SEQ_WDOG_EN
- Defined: a free counter runs while in LOCK_WAIT and clears on exit. On reaching LOCK_TIMEOUT it sets lock_timeout=1, which stays set until rstn=0. Sequencing is not otherwise altered.
- Undefined: no counter is instantiated and lock_timeout is tied 0.

Decomposition:
- Package reset_seq_pkg holds the state enum with the state_dbg encoding above and a width helper function.
- One sub-module is natural: rst_timer, a loadable saturating down-counter with a done flag. It is shared by the PHY_RST, PHY_WAKE and RELEASE stage timing.

Test Plan:
Test parameters: NUM_DOMAINS=3, LOCK_FILT=3, PHY_RST_CYCLES=10, PHY_WAKE_CYCLES=5, STAGE_CYCLES=4.
- Lock held high from edge k -> rgmii_rstn rises at k+12; dom_rst[0] clears at k+17, dom_rst[1] at k+21, dom_rst[2] at k+25; ready=1 at k+25; state_dbg=4.
- pll_lock toggles 1,1,0,1,1,1 -> filter restarts; PHY_RST is entered only after the third consecutive high sample.
- Lock drop at k+19 -> at k+20: dom_rst=3'b111, rgmii_rstn=0, ready=0, state_dbg=0; re-lock repeats the full sequence.
- sw_rst pulse in RUN -> next edge dom_rst=3'b111, ready=0, rgmii_rstn stays 1; dom_rst[0] clears 5 edges later, then 4-cycle staging.
- rstn asserted mid-RELEASE -> next edge: all outputs at reset values. Same-cycle sw_rst and lock loss -> state goes to LOCK_WAIT.
- With RESET_SEQ_WDOG_EN and LOCK_TIMEOUT=20, lock held low -> lock_timeout=1 after 20 cycles, and it stays 1 when lock later arrives.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq shared types: FSM state encoding and counter width helper.
// Optional watchdog build macro: RESET_SEQ_WDOG_EN.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_LOCK_WAIT = 3'd0,
    S_PHY_RST   = 3'd1,
    S_PHY_WAKE  = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  function automatic int cnt_w(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_seq_if.sv
// reset_seq bus: PLL/soft-reset inputs and PHY/domain reset outputs.
// master = sequencer, slave = the logic being reset.
interface reset_seq_if #(
  parameter int NUM_DOMAINS = 2
);

  logic                   pll_lock;
  logic                   sw_rst;
  logic                   rgmii_rstn;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   ready;
  logic [2:0]             state_dbg;
  logic                   lock_timeout;

  modport master (
    input  pll_lock,
    input  sw_rst,
    output rgmii_rstn,
    output dom_rst,
    output ready,
    output state_dbg,
    output lock_timeout
  );

  modport slave (
    output pll_lock,
    output sw_rst,
    input  rgmii_rstn,
    input  dom_rst,
    input  ready,
    input  state_dbg,
    input  lock_timeout
  );

endinterface

// File: rtl/reset_seq_timer.sv
// rst_timer: loadable saturating down-counter; done while it reads zero.
// Shared by PHY reset, PHY wake-up and domain staging intervals.
module rst_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/reset_seq.sv
// reset_seq: PLL lock filter, PHY reset/wake timing, staged domain release.
// Define RESET_SEQ_WDOG_EN to add the sticky LOCK_WAIT watchdog flag.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 2,
  parameter int LOCK_FILT       = 8,
  parameter int PHY_RST_CYCLES  = 1000,
  parameter int PHY_WAKE_CYCLES = 500,
  parameter int STAGE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT    = 65536
) (
  input logic         clk,
  input logic         rstn,
  reset_seq_if.master bus
);

  localparam int CNT_W = cnt_w(LOCK_FILT, PHY_RST_CYCLES,
                               PHY_WAKE_CYCLES, STAGE_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Timers are loaded with N-1 so a state lasting N cycles exits on its Nth edge
  localparam logic [CNT_W-1:0] FILT_LD  = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(PHY_WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LD = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  state_e                 state_q, state_d;
  logic                   rgmii_q, rgmii_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic                   tmr_ld;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_done;

  rst_timer #(
    .W (CNT_W)
  ) u_tmr (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (tmr_ld),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    rgmii_d    = rgmii_q;
    dom_d      = dom_q;
    ready_d    = ready_q;
    lock_cnt_d = lock_cnt_q;
    idx_d      = idx_q;
    tmr_ld     = 1'b0;
    tmr_val    = '0;

    if (state_q != S_LOCK_WAIT && !bus.pll_lock) begin
      state_d    = S_LOCK_WAIT;
      rgmii_d    = 1'b0;
      dom_d      = '1;
      ready_d    = 1'b0;
      lock_cnt_d = '0;
      idx_d      = '0;
      tmr_ld     = 1'b1;
    end else if ((state_q == S_RELEASE || state_q == S_RUN)
                 && bus.sw_rst) begin
      state_d = S_PHY_WAKE;
      dom_d   = '1;
      ready_d = 1'b0;
      idx_d   = '0;
      tmr_ld  = 1'b1;
      tmr_val = WAKE_LD;
    end else begin
      unique case (state_q)
        S_LOCK_WAIT: begin
          if (!bus.pll_lock) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == FILT_LD) begin
            state_d    = S_PHY_RST;
            lock_cnt_d = '0;
            tmr_ld     = 1'b1;
            tmr_val    = RST_LD;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end
        S_PHY_RST: begin
          if (tmr_done) begin
            state_d = S_PHY_WAKE;
            rgmii_d = 1'b1;
            tmr_ld  = 1'b1;
            tmr_val = WAKE_LD;
          end
        end
        S_PHY_WAKE: begin
          if (tmr_done) begin
            dom_d = dom_q << 1;
            if (NUM_DOMAINS == 1) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = S_RELEASE;
              idx_d   = IDX_W'(1);
              tmr_ld  = 1'b1;
              tmr_val = STAGE_LD;
            end
          end
        end
        S_RELEASE: begin
          // Shifting zeros in from bit 0 keeps releases strictly in order
          if (tmr_done) begin
            dom_d = dom_q << 1;
            if (idx_q == LAST_IDX) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              tmr_ld  = 1'b1;
              tmr_val = STAGE_LD;
            end
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_LOCK_WAIT;
          rgmii_d = 1'b0;
          dom_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_LOCK_WAIT;
      rgmii_q    <= 1'b0;
      dom_q      <= '1;
      ready_q    <= 1'b0;
      lock_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      rgmii_q    <= rgmii_d;
      dom_q      <= dom_d;
      ready_q    <= ready_d;
      lock_cnt_q <= lock_cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.rgmii_rstn = rgmii_q;
  assign bus.dom_rst    = dom_q;
  assign bus.ready      = ready_q;
  assign bus.state_dbg  = state_q;

`ifdef RESET_SEQ_WDOG_EN
  localparam int WD_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 1);

  logic [WD_W-1:0] wd_q;
  logic            to_q;

  // Counter restarts on every LOCK_WAIT entry; the flag only clears on rstn
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (state_q != S_LOCK_WAIT) begin
      wd_q <= '0;
    end else if (wd_q == WD_LAST) begin
      to_q <= 1'b1;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign bus.lock_timeout = to_q;
`else
  assign bus.lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// reset_seq bench: directed scenarios plus random lock/sw_rst/rstn traffic.
// Reference model works from timestamps since lock-filter completion.
module tb_reset_seq;

  localparam int ND = 3;
  localparam int LF = 3;
  localparam int PR = 10;
  localparam int PW = 5;
  localparam int SC = 4;
  localparam int LT = 20;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  reset_seq_if #(.NUM_DOMAINS(ND)) bus();

  reset_seq #(
    .NUM_DOMAINS     (ND),
    .LOCK_FILT       (LF),
    .PHY_RST_CYCLES  (PR),
    .PHY_WAKE_CYCLES (PW),
    .STAGE_CYCLES    (SC),
    .LOCK_TIMEOUT    (LT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  bit m_locked = 1'b0;
  int m_run    = 0;
  int m_t      = 0;
  int m_base   = 0;
  int m_wd     = 0;
  bit m_to     = 1'b0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h exp %0h", tag, $time, got, exp);
    end
  endtask

  // m_t counts edges since the filter completed; domain i is released once
  // m_t reaches m_base + i*SC, where m_base moves on each honoured sw_rst.
  task automatic model_edge(input bit r, input bit l, input bit s);
    if (!r) begin
      m_locked = 1'b0;
      m_run    = 0;
      m_wd     = 0;
      m_to     = 1'b0;
    end else begin
      if (!m_locked) begin
        m_wd++;
        if (m_wd >= LT) m_to = 1'b1;
      end else begin
        m_wd = 0;
      end
      if (!m_locked) begin
        m_run = l ? m_run + 1 : 0;
        if (m_run == LF) begin
          m_locked = 1'b1;
          m_t      = 0;
          m_base   = PR + PW;
          m_run    = 0;
        end
      end else if (!l) begin
        m_locked = 1'b0;
        m_run    = 0;
      end else begin
        if (s && m_t >= m_base) m_base = m_t + 1 + PW;
        m_t++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [ND-1:0] ed;
    logic [2:0]    es;
    int            last;
    bit            to_exp;
    last = m_base + (ND - 1) * SC;
    for (int i = 0; i < ND; i++)
      ed[i] = !(m_locked && m_t >= m_base + i * SC);
    if (!m_locked)        es = 3'd0;
    else if (m_t < PR)    es = 3'd1;
    else if (m_t < m_base) es = 3'd2;
    else if (m_t < last)  es = 3'd3;
    else                  es = 3'd4;
`ifdef RESET_SEQ_WDOG_EN
    to_exp = m_to;
`else
    to_exp = 1'b0;
`endif
    check("rgmii_rstn", 32'(bus.rgmii_rstn), 32'(m_locked && m_t >= PR));
    check("dom_rst", 32'(bus.dom_rst), 32'(ed));
    check("ready", 32'(bus.ready), 32'(m_locked && m_t >= last));
    check("state_dbg", 32'(bus.state_dbg), 32'(es));
    check("lock_timeout", 32'(bus.lock_timeout), 32'(to_exp));
  endtask

  task automatic step(input bit r, input bit l, input bit s);
    rstn         = r;
    bus.pll_lock = l;
    bus.sw_rst   = s;
    @(posedge clk);
    model_edge(r, l, s);
    #1;
    check_outputs();
  endtask

  task automatic hold(input bit r, input bit l, input int n);
    for (int i = 0; i < n; i++) step(r, l, 1'b0);
  endtask

  initial begin
    int low_left;
    bit r;
    bit l;
    bit s;
    bus.pll_lock = 1'b0;
    bus.sw_rst   = 1'b0;

    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b1, 30);

    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 20);

    hold(1'b1, 1'b0, 3);

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    hold(1'b1, 1'b1, 30);

    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 2);

    hold(1'b1, 1'b1, 19);
    hold(1'b1, 1'b0, 2);

    hold(1'b1, 1'b1, 20);
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 8);
    step(1'b0, 1'b1, 1'b0);
    hold(1'b1, 1'b1, 30);

    hold(1'b0, 1'b0, 1);
    hold(1'b1, 1'b0, 25);
    hold(1'b1, 1'b1, 30);

    low_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (low_left == 0 && $urandom_range(0, 119) == 0)
        low_left = $urandom_range(1, 5);
      l = (low_left == 0);
      if (low_left != 0) low_left--;
      s = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 699) != 0);
      step(r, l, s);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
